// File: rtl/adc_spi_sampler_pkg.sv
// rtl/adc_spi_sampler_pkg.sv - FSM encoding and default ADC timing shared by the sampler files
package adc_spi_sampler_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CONVERT = 2'd1,
      ST_SHIFT   = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   localparam int DEF_CLK_DIV       = 4;
   localparam int DEF_DATA_BITS     = 16;
   localparam int DEF_CONV_CYCLES   = 50;
   localparam int DEF_SAMPLE_PERIOD = 1000;

   // Width of a counter that runs 0..n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/adc_spi_sampler_spi_rx_shifter.sv
// rtl/adc_spi_sampler_spi_rx_shifter.sv - SCK divider, bit counter and MSB-first MISO shift register
module adc_spi_sampler_spi_rx_shifter
   import adc_spi_sampler_pkg::*;
#(
   parameter int CLK_DIV   = DEF_CLK_DIV,
   parameter int DATA_BITS = DEF_DATA_BITS
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_start,
   input  logic                 i_miso,
   output logic                 o_sck,
   output logic                 o_done,
   output logic [DATA_BITS-1:0] o_data
);

   localparam int DW = cnt_width(CLK_DIV);
   localparam int EW = cnt_width(2 * DATA_BITS);
   localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
   localparam logic [EW-1:0] EDGE_LAST = EW'(2 * DATA_BITS - 1);

   logic                 r_active;
   logic [DW-1:0]        r_div;
   logic [EW-1:0]        r_edges;
   logic                 r_sck;
   logic [DATA_BITS-1:0] r_shift;
   logic                 w_toggle;

   assign w_toggle = r_active && (r_div == DIV_LAST);
   // o_done marks the last shifting cycle, i.e. the one ending in the final SCK fall.
   assign o_done   = w_toggle && (r_edges == EDGE_LAST);
   assign o_sck    = r_sck;
   assign o_data   = r_shift;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_active <= 1'b0;
         r_div    <= '0;
         r_edges  <= '0;
         r_sck    <= 1'b0;
         r_shift  <= '0;
      end else if (i_start) begin
         r_active <= 1'b1;
         r_div    <= '0;
         r_edges  <= '0;
         r_sck    <= 1'b0;
         r_shift  <= '0;
      end else if (r_active) begin
         if (w_toggle) begin
            r_div   <= '0;
            r_sck   <= ~r_sck;
            r_edges <= r_edges + EW'(1);
            if (!r_sck) begin
               r_shift <= {r_shift[DATA_BITS-2:0], i_miso};
            end
            if (o_done) begin
               r_active <= 1'b0;
            end
         end else begin
            r_div <= r_div + DW'(1);
         end
      end
   end

endmodule

// File: rtl/adc_spi_sampler.sv
// rtl/adc_spi_sampler.sv - periodic CONVST/SPI ADC capture with a valid/ready holding register
module adc_spi_sampler
   import adc_spi_sampler_pkg::*;
#(
   parameter int CLK_DIV       = DEF_CLK_DIV,
   parameter int DATA_BITS     = DEF_DATA_BITS,
   parameter int CONV_CYCLES   = DEF_CONV_CYCLES,
   parameter int SAMPLE_PERIOD = DEF_SAMPLE_PERIOD
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   output logic                 adc_convst,
   output logic                 adc_cs_n,
   output logic                 adc_sck,
   input  logic                 adc_miso,
   output logic [DATA_BITS-1:0] sample_data,
   output logic                 sample_valid,
   input  logic                 sample_ready,
   output logic [7:0]           overrun_count,
   output logic                 busy
);

   localparam int PW = cnt_width(SAMPLE_PERIOD);
   localparam int CW = cnt_width(CONV_CYCLES);
   localparam logic [PW-1:0] PERIOD_LAST = PW'(SAMPLE_PERIOD - 1);
   localparam logic [CW-1:0] CONV_LAST   = CW'(CONV_CYCLES - 1);

   state_t               r_state;
   state_t               w_next_state;
   logic [PW-1:0]        r_period;
   logic [CW-1:0]        r_conv_cnt;
   logic                 r_convst;
   logic                 r_cs_n;
   logic [DATA_BITS-1:0] r_data;
   logic                 r_valid;
   logic [7:0]           r_overrun;
   logic                 w_trigger;
   logic                 w_conv_last;
   logic                 w_shift_start;
   logic                 w_shift_done;
   logic                 w_convst_d;
   logic                 w_cs_n_d;
   logic [DATA_BITS-1:0] w_shift_data;

   assign w_trigger   = enable && (r_period == PERIOD_LAST);
   assign w_conv_last = (r_state == ST_CONVERT) && (r_conv_cnt == CONV_LAST);

   always_ff @(posedge clk) begin
      if (rst || !enable || (r_period == PERIOD_LAST)) begin
         r_period <= '0;
      end else begin
         r_period <= r_period + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_conv_cnt <= '0;
         r_convst   <= 1'b0;
         r_cs_n     <= 1'b1;
      end else begin
         r_state    <= w_next_state;
         r_conv_cnt <= (r_state == ST_CONVERT) ? r_conv_cnt + CW'(1) : '0;
         r_convst   <= w_convst_d;
         r_cs_n     <= w_cs_n_d;
      end
   end

   // Outputs are decoded from the next state so they line up with the state register.
   always_comb begin
      w_next_state  = r_state;
      w_shift_start = 1'b0;
      case (r_state)
         ST_IDLE:    if (w_trigger) w_next_state = ST_CONVERT;
         ST_CONVERT: begin
            if (w_conv_last) begin
               w_next_state  = ST_SHIFT;
               w_shift_start = 1'b1;
            end
         end
         ST_SHIFT:   if (w_shift_done) w_next_state = ST_DONE;
         ST_DONE:    w_next_state = ST_IDLE;
         default:    w_next_state = ST_IDLE;
      endcase
      w_convst_d = (w_next_state == ST_CONVERT);
      w_cs_n_d   = (w_next_state != ST_SHIFT);
   end

   adc_spi_sampler_spi_rx_shifter #(
      .CLK_DIV   (CLK_DIV),
      .DATA_BITS (DATA_BITS)
   ) u_rx (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_start (w_shift_start),
      .i_miso  (adc_miso),
      .o_sck   (adc_sck),
      .o_done  (w_shift_done),
      .o_data  (w_shift_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_overrun <= 8'd0;
      end else if (r_state == ST_DONE) begin
         if (!r_valid || sample_ready) begin
            r_data  <= w_shift_data;
            r_valid <= 1'b1;
         end else if (r_overrun != 8'hFF) begin
            r_overrun <= r_overrun + 8'd1;
         end
      end else if (r_valid && sample_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign adc_convst    = r_convst;
   assign adc_cs_n      = r_cs_n;
   assign sample_data   = r_data;
   assign sample_valid  = r_valid;
   assign overrun_count = r_overrun;
   assign busy          = (r_state != ST_IDLE);

endmodule

// File: tb/tb_adc_spi_sampler.sv
// tb/tb_adc_spi_sampler.sv - directed and randomized checks of adc_spi_sampler against a timing model
module tb_adc_spi_sampler;

   localparam int K  = 2;
   localparam int D  = 16;
   localparam int C  = 4;
   localparam int P  = 100;
   localparam int SH = 2 * K * D;
   localparam int DN = C + SH + 1;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         enable = 1'b1;
   logic         sample_ready = 1'b0;
   logic         adc_convst, adc_cs_n, adc_sck, adc_miso;
   logic [D-1:0] sample_data;
   logic         sample_valid;
   logic [7:0]   overrun_count;
   logic         busy;

   adc_spi_sampler #(
      .CLK_DIV       (K),
      .DATA_BITS     (D),
      .CONV_CYCLES   (C),
      .SAMPLE_PERIOD (P)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .enable        (enable),
      .adc_convst    (adc_convst),
      .adc_cs_n      (adc_cs_n),
      .adc_sck       (adc_sck),
      .adc_miso      (adc_miso),
      .sample_data   (sample_data),
      .sample_valid  (sample_valid),
      .sample_ready  (sample_ready),
      .overrun_count (overrun_count),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   // ADC: presents the word MSB first, advancing one bit per SCK fall.
   logic [D-1:0] adc_word = '0;
   int           fall_idx = 0;
   always @(negedge adc_sck or posedge adc_cs_n) begin
      if (adc_cs_n) fall_idx = 0;
      else          fall_idx = fall_idx + 1;
   end
   always_comb adc_miso = (fall_idx < D) ? adc_word[D-1-fall_idx] : 1'b0;

   int           total = 0, bad = 0;
   int           cyc = 0, m_t0 = 0, m_per = 0, m_ovr = 0, m_ndone = 0;
   bit           m_act = 1'b0, m_valid = 1'b0;
   logic [D-1:0] m_word = '0, m_data = '0;
   logic [D-1:0] word_q[$];
   int           n_convst = 0, n_rise = 0, n_valid = 0, v_cyc = -1;
   bit           prev_sck = 1'b0;

   typedef struct {
      bit         rst, en, rdy;
      bit         e_cs_n, e_sck, e_convst, e_valid, e_busy;
      logic [7:0] e_ovr;
   } vec_t;
   vec_t vecs[5];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic int off();
      return cyc - m_t0;
   endfunction

   function automatic bit m_in(input int lo, input int hi);
      return m_act && (off() >= lo) && (off() <= hi);
   endfunction

   function automatic bit m_is_done();
      return m_in(DN, DN);
   endfunction

   // Capture timeline as offsets from the trigger cycle; holding-register rules applied at each edge.
   task automatic model_edge();
      bit trig;
      if (rst) begin
         m_act = 1'b0; m_valid = 1'b0; m_data = '0; m_ovr = 0; m_per = 0;
      end else begin
         trig = enable && (m_per == P - 1) && !m_in(1, DN);
         if (m_is_done()) begin
            m_ndone++;
            if (!m_valid || sample_ready) begin
               m_data = m_word; m_valid = 1'b1;
            end else if (m_ovr < 255) begin
               m_ovr++;
            end
            m_act = 1'b0;
         end else if (m_valid && sample_ready) begin
            m_valid = 1'b0;
         end
         if (trig) begin
            m_act = 1'b1;
            m_t0  = cyc;
            if (word_q.size() > 0) m_word = word_q.pop_front();
            else                   m_word = D'($urandom);
            adc_word = m_word;
         end
         m_per = enable ? ((m_per == P - 1) ? 0 : m_per + 1) : 0;
      end
      cyc++;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("convst",  adc_convst, m_in(1, C));
      chk("cs_n",    adc_cs_n, !m_in(C + 1, C + SH));
      chk("sck",     adc_sck, m_in(C + 1, C + SH) && ((((off() - C - 1) / K) % 2) == 1));
      chk("busy",    busy, m_in(1, DN));
      chk("valid",   sample_valid, m_valid);
      chk("data",    sample_data, m_data);
      chk("overrun", overrun_count, m_ovr);
      if (adc_convst) n_convst++;
      if (adc_sck && !prev_sck) n_rise++;
      prev_sck = adc_sck;
      if (sample_valid) begin
         n_valid++;
         if (n_valid == 1) v_cyc = cyc;
      end
   endtask

   task automatic wait_done(input string nm, input int lim);
      int n = 0;
      while (!m_is_done() && n < lim) begin
         step();
         n++;
      end
      chk(nm, m_is_done(), 1);
   endtask

   task automatic wait_off(input string nm, input int o, input int lim);
      int n = 0;
      while (!m_in(o, o) && n < lim) begin
         step();
         n++;
      end
      chk(nm, m_in(o, o), 1);
   endtask

   initial begin
      vecs[0] = '{1, 1, 0, 1, 0, 0, 0, 0, 8'd0};
      vecs[1] = '{1, 1, 0, 1, 0, 0, 0, 0, 8'd0};
      vecs[2] = '{1, 1, 0, 1, 0, 0, 0, 0, 8'd0};
      vecs[3] = '{0, 1, 1, 1, 0, 0, 0, 0, 8'd0};
      vecs[4] = '{0, 1, 1, 1, 0, 0, 0, 0, 8'd0};
      for (int i = 0; i < 5; i++) begin
         rst = vecs[i].rst; enable = vecs[i].en; sample_ready = vecs[i].rdy;
         step();
         chk("tbl_cs_n",   adc_cs_n, vecs[i].e_cs_n);
         chk("tbl_sck",    adc_sck, vecs[i].e_sck);
         chk("tbl_convst", adc_convst, vecs[i].e_convst);
         chk("tbl_valid",  sample_valid, vecs[i].e_valid);
         chk("tbl_busy",   busy, vecs[i].e_busy);
         chk("tbl_ovr",    overrun_count, vecs[i].e_ovr);
      end

      // Single capture
      word_q.push_back(16'hA5C3);
      n_convst = 0; n_rise = 0; n_valid = 0; v_cyc = -1;
      wait_done("p1_done", 200);
      step();
      step();
      chk("p1_convst_cycles", n_convst, 4);
      chk("p1_sck_rises", n_rise, 16);
      chk("p1_valid_cycles", n_valid, 1);
      chk("p1_valid_at", v_cyc - m_t0, 70);
      chk("p1_data", sample_data, 16'hA5C3);

      // Back-pressure across three periods
      sample_ready = 1'b0;
      word_q.push_back(16'h1111); word_q.push_back(16'h2222); word_q.push_back(16'h3333);
      for (int i = 0; i < 3; i++) begin
         wait_done("p2_done", 150);
         step();
      end
      chk("p2_data", sample_data, 16'h1111);
      chk("p2_ovr", overrun_count, 2);
      chk("p2_valid", sample_valid, 1);
      sample_ready = 1'b1;
      step();
      chk("p2_valid_drop", sample_valid, 0);

      // Ready arriving in the DONE cycle
      sample_ready = 1'b0;
      word_q.push_back(16'h1111); word_q.push_back(16'h2222);
      wait_done("p3_first", 150);
      step();
      chk("p3_hold", sample_data, 16'h1111);
      wait_done("p3_second", 150);
      sample_ready = 1'b1;
      step();
      chk("p3_valid", sample_valid, 1);
      chk("p3_data", sample_data, 16'h2222);
      chk("p3_ovr", overrun_count, 2);
      step();

      // Enable dropped mid-SHIFT
      word_q.push_back(16'hBEEF);
      wait_off("p4_shift", C + 10, 150);
      enable = 1'b0;
      wait_done("p4_done", 100);
      step();
      chk("p4_valid", sample_valid, 1);
      chk("p4_data", sample_data, 16'hBEEF);
      n_convst = 0;
      repeat (3 * P) step();
      chk("p4_no_convst", n_convst, 0);

      // Reset mid-SHIFT
      enable = 1'b1;
      word_q.push_back(16'h1234); word_q.push_back(16'h5678);
      wait_off("p5_shift", C + 20, 250);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("p5_cs_n", adc_cs_n, 1);
      chk("p5_sck", adc_sck, 0);
      chk("p5_valid", sample_valid, 0);
      chk("p5_busy", busy, 0);
      wait_done("p5_done", 250);
      step();
      chk("p5_valid_after", sample_valid, 1);
      chk("p5_data", sample_data, 16'h5678);

      // Randomized traffic checked cycle by cycle against the model
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 399) == 0) enable = ~enable;
         if ((i / 500) % 2 == 0) sample_ready = ($urandom_range(0, 3) != 0);
         else                    sample_ready = ($urandom_range(0, 3) == 0);
         step();
      end
      rst = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
